alu_ctrl: RTL and testbench

Instruction sequencer driving the 8-bit ALU from the opposite side of its operand/select interface. Accepts one 32-bit instruction per handshake, reads operands from an internal 8×8 register file, and drives ALU DATA1/DATA2/SELECT. It then captures RESULT and writes it back to the destination register. It sits between the instruction source (fetch stage or bench) and the ALU in the integrated processor.

---
 rtl/alu_ctrl.sv | 93 +++++++++
 tb/tb_alu_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl: 3-cycle instruction sequencer with an 8x8 register file that drives an external 8-bit ALU.
// Define ALU_SUB_EN to decode opcode 0x03 (sub); otherwise 0x03 is an illegal opcode.
module alu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  alu_data1,
    output logic [7:0]  alu_data2,
    output logic [2:0]  alu_select,
    input  logic [7:0]  alu_result,
    output logic        done,
    output logic        error,
    input  logic [2:0]  reg_raddr,
    output logic [7:0]  reg_rdata
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;
    state_t      state;
    logic [7:0]  regs [8];
    logic [7:0]  op, imm;
    logic [2:0]  dest, src1;
    logic [7:0]  ra, rb, d1, d2, sub_d2;
    logic [2:0]  sel;
    logic        legal, sub_ok, unused_bits;
    assign unused_bits = ^{instr[23:19], instr[15:11]};
    assign ra = regs[src1];
    assign rb = regs[imm[2:0]];
    assign reg_rdata = regs[reg_raddr];
`ifdef ALU_SUB_EN
    assign sub_ok = 1'b1;
    assign sub_d2 = ~rb + 8'd1;
`else
    assign sub_ok = 1'b0;
    assign sub_d2 = 8'h00;
`endif
    always_comb begin
        legal = (op <= 8'h05) && (op != 8'h03 || sub_ok);
        d1 = (op == 8'h00 || op == 8'h01) ? alu_data1 : ra;
        d2 = op == 8'h00 ? imm : op == 8'h03 ? sub_d2 : rb;
        sel = (op == 8'h02 || op == 8'h03) ? 3'b001 :
              op == 8'h04 ? 3'b010 : op == 8'h05 ? 3'b011 : 3'b000;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            instr_ready <= 1'b1;
            done <= 1'b0;
            error <= 1'b0;
            alu_data1 <= '0;
            alu_data2 <= '0;
            alu_select <= '0;
            op <= '0;
            imm <= '0;
            dest <= '0;
            src1 <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (instr_valid && instr_ready) begin
                        op <= instr[31:24];
                        dest <= instr[18:16];
                        src1 <= instr[10:8];
                        imm <= instr[7:0];
                        instr_ready <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        alu_data1 <= d1;
                        alu_data2 <= d2;
                        alu_select <= sel;
                        state <= EXEC;
                    end else begin
                        error <= 1'b1;
                        instr_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    regs[dest] <= alu_result;
                    done <= 1'b1;
                    instr_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed self-checking bench for alu_ctrl with a behavioural ALU model.
module tb_alu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready, done, error;
    logic [7:0]  alu_data1, alu_data2, alu_result, reg_rdata;
    logic [2:0]  alu_select;
    logic [2:0]  reg_raddr = '0;
    int checks = 0;
    int errors = 0;
    logic       r_ready0, r_ready1, r_ready2, r_err, r_done;
    logic [7:0] r_d1, r_d2;
    logic [2:0] r_sel;
    int acc, dn;

    alu_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_select(alu_select), .alu_result(alu_result), .done(done), .error(error),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    always_comb
        alu_result = alu_select == 3'b000 ? alu_data2 :
                     alu_select == 3'b001 ? alu_data1 + alu_data2 :
                     alu_select == 3'b010 ? (alu_data1 & alu_data2) :
                     alu_select == 3'b011 ? (alu_data1 | alu_data2) : 8'h00;

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] dst,
                                       input logic [2:0] s1, input logic [7:0] low);
        return {op, 5'b0, dst, 5'b0, s1, low};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] e);
        reg_raddr = a;
        #1;
        check(tag, reg_rdata, e);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic exec_instr(input logic [31:0] w);
        instr = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        r_ready0 = instr_ready;
        tick();
        r_sel = alu_select;
        r_d1 = alu_data1;
        r_d2 = alu_data2;
        r_err = error;
        r_ready1 = instr_ready;
        tick();
        r_done = done;
        r_ready2 = instr_ready;
    endtask

    initial begin
        do_reset();
        check("rst_ready", instr_ready, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_sel", alu_select, 0);
        check("rst_d1", alu_data1, 0);
        check("rst_d2", alu_data2, 0);
        rd("rst_r0", 3'd0, 8'h00);

        exec_instr(mk(8'h00, 3'd1, 3'd0, 8'h05));
        check("loadi_busy", r_ready0, 0);
        check("loadi_d2", r_d2, 8'h05);
        check("loadi_sel", r_sel, 3'b000);
        check("loadi_done", r_done, 1);
        check("loadi_ready", r_ready2, 1);
        exec_instr(mk(8'h00, 3'd2, 3'd0, 8'h03));
        check("loadi2_done", r_done, 1);
        exec_instr(mk(8'h02, 3'd3, 3'd1, 8'd2));
        check("add_sel", r_sel, 3'b001);
        check("add_d1", r_d1, 8'h05);
        check("add_d2", r_d2, 8'h03);
        check("add_done", r_done, 1);
        rd("add_r3", 3'd3, 8'h08);
        tick();
        check("done_pulse", done, 0);

        exec_instr(mk(8'h00, 3'd1, 3'd0, 8'hF0));
        exec_instr(mk(8'h00, 3'd2, 3'd0, 8'h3C));
        exec_instr(mk(8'h04, 3'd4, 3'd1, 8'd2));
        check("and_sel", r_sel, 3'b010);
        exec_instr(mk(8'h05, 3'd5, 3'd1, 8'd2));
        check("or_sel", r_sel, 3'b011);
        rd("and_r4", 3'd4, 8'h30);
        rd("or_r5", 3'd5, 8'hFC);
        exec_instr(mk(8'h00, 3'd1, 3'd0, 8'hFF));
        exec_instr(mk(8'h00, 3'd2, 3'd0, 8'h02));
        exec_instr(mk(8'h02, 3'd6, 3'd1, 8'd2));
        rd("add_wrap_r6", 3'd6, 8'h01);

        exec_instr(mk(8'h00, 3'd1, 3'd0, 8'h05));
        exec_instr(mk(8'h00, 3'd2, 3'd0, 8'h03));
        exec_instr(mk(8'h03, 3'd7, 3'd2, 8'd1));
`ifdef ALU_SUB_EN
        check("sub_d2", r_d2, 8'hFB);
        check("sub_d1", r_d1, 8'h03);
        check("sub_done", r_done, 1);
        check("sub_err", error, 0);
        rd("sub_r7", 3'd7, 8'hFE);
`else
        check("nosub_err", r_err, 1);
        check("nosub_ready", r_ready1, 1);
        check("nosub_done", r_done, 0);
        rd("nosub_r7", 3'd7, 8'h00);
`endif

        do_reset();
        check("rst2_error", error, 0);
        rd("rst2_r6", 3'd6, 8'h00);
        exec_instr(mk(8'h07, 3'd1, 3'd0, 8'h00));
        check("ill_err", r_err, 1);
        check("ill_ready", r_ready1, 1);
        check("ill_done", r_done, 0);
        rd("ill_r1", 3'd1, 8'h00);
        exec_instr(mk(8'h00, 3'd1, 3'd0, 8'h11));
        check("ill_sticky", error, 1);
        check("after_ill_done", r_done, 1);
        rd("after_ill_r1", 3'd1, 8'h11);
        do_reset();
        check("ill_cleared", error, 0);

        exec_instr(mk(8'h00, 3'd1, 3'd0, 8'h02));
        exec_instr(mk(8'h00, 3'd2, 3'd0, 8'h03));
        acc = 0;
        dn = 0;
        instr = mk(8'h02, 3'd3, 3'd1, 8'd2);
        instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (instr_ready) acc++;
            tick();
            if (done) dn++;
        end
        instr_valid = 1'b0;
        check("hold_accepts", acc, 3);
        check("hold_dones", dn, 3);
        rd("hold_r3", 3'd3, 8'h05);
        exec_instr(mk(8'h01, 3'd0, 3'd0, 8'd3));
        check("mov_sel", r_sel, 3'b000);
        rd("mov_r0", 3'd0, 8'h05);

        instr = mk(8'h00, 3'd1, 3'd0, 8'hAA);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("abort_d2_pre", alu_data2, 8'hAA);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_done", done, 0);
        check("abort_ready", instr_ready, 1);
        check("abort_d2", alu_data2, 8'h00);
        rd("abort_r1", 3'd1, 8'h00);
        rd("abort_r0", 3'd0, 8'h00);
        tick();
        check("abort_no_late_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
